// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller and fetch_cycle.
// IRQ_EDGE_EN (see irq_controller) selects edge-triggered pending capture.
package irq_pkg;

  // Controller FSM encoding
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFire    = 2'd1,
    StService = 2'd2
  } irq_state_e;

  // Fetch redirect target, also used by fetch_cycle
  localparam logic [31:0] INTERRUPT_VECTOR = 32'h0000_0100;

  // Width of the serviced-source index
  localparam int unsigned IdW = 5;

endpackage

// File: rtl/irq_prio_enc.sv
// Priority encoder: index of the lowest set request bit (bit 0 wins), plus valid.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] req,
  output logic [IdW-1:0]   idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (req[i]) idx = IdW'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt source controller feeding the fetch-stage redirect.
// Masks and prioritises NUM_SRC requests, drives `interrupt` while in FIRE, captures EPC on
// the cycle fetch actually redirects and holds it until mret.
// Build option: define IRQ_EDGE_EN for rising-edge pending capture; default is level mode.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               Stall_F,
  input  logic               PCSrc_E,
  input  logic [31:0]        PC_Target_E,
  input  logic [31:0]        PC_plus4_F,
  input  logic               mret_E,
  output logic               interrupt,
  output logic [IdW-1:0]     irq_id,
  output logic [31:0]        epc,
  output logic               in_service,
  output logic [NUM_SRC-1:0] irq_mask
);

  irq_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] active;
  logic [IdW-1:0]     sel_idx;
  logic               sel_valid;
  logic [IdW-1:0]     irq_id_q;
  logic [31:0]        epc_q;
  logic               take;

  // Fetch redirects on the first unstalled FIRE cycle
  assign take   = (state_q == StFire) && !Stall_F;
  assign active = pending & mask_q;

  irq_prio_enc #(
    .Width(NUM_SRC)
  ) u_prio_enc (
    .req  (active),
    .idx  (sel_idx),
    .valid(sel_valid)
  );

`ifdef IRQ_EDGE_EN
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] clr;

  // Clear the taken source, then OR in new rising edges so a same-cycle set wins
  always_comb begin
    clr = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (take && (irq_id_q == IdW'(i))) clr[i] = 1'b1;
    end
    pending_d = (pending_q & ~clr) | (irq_src & ~prev_q);
  end

  // Edge-detect history and sticky pending bits
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q    <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= irq_src;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
`else
  // Level mode: the source itself is the request until the handler acknowledges it
  assign pending = irq_src;
`endif

  // Next-state logic; mret is only honoured while in SERVICE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (sel_valid) state_d = StFire;
      StFire:    if (!Stall_F)  state_d = StService;
      StService: if (mret_E)    state_d = StIdle;
      default:                  state_d = StIdle;
    endcase
  end

  // State, mask, selected id and return address registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      mask_q   <= '0;
      irq_id_q <= '0;
      epc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (mask_we) mask_q <= mask_wdata;
      // irq_id stays frozen from arbitration through service
      if ((state_q == StIdle) && sel_valid) irq_id_q <= sel_idx;
      // Interrupt beats a same-cycle branch in the fetch mux, so the branch target is the resume PC
      if (take) epc_q <= PCSrc_E ? PC_Target_E : PC_plus4_F;
    end
  end

  assign interrupt  = (state_q == StFire);
  assign in_service = (state_q == StService);
  assign irq_id     = irq_id_q;
  assign epc        = epc_q;
  assign irq_mask   = mask_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller (NUM_SRC = 8).
// Sequences are written to hold in both level and IRQ_EDGE_EN builds.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_src;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic        Stall_F;
  logic        PCSrc_E;
  logic [31:0] PC_Target_E;
  logic [31:0] PC_plus4_F;
  logic        mret_E;
  logic        interrupt;
  logic [4:0]  irq_id;
  logic [31:0] epc;
  logic        in_service;
  logic [7:0]  irq_mask;

  int tests = 0;
  int fails = 0;
  bit ok;

  irq_controller #(
    .NUM_SRC(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src    (irq_src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .Stall_F    (Stall_F),
    .PCSrc_E    (PCSrc_E),
    .PC_Target_E(PC_Target_E),
    .PC_plus4_F (PC_plus4_F),
    .mret_E     (mret_E),
    .interrupt  (interrupt),
    .irq_id     (irq_id),
    .epc        (epc),
    .in_service (in_service),
    .irq_mask   (irq_mask)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are read 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for interrupt to rise
  task automatic wait_irq(output bit found);
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (interrupt === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_mret();
    mret_E = 1'b1;
    tick();
    mret_E = 1'b0;
  endtask

  initial begin
    rst = 1'b0; irq_src = 8'hFF; mask_we = 1'b0; mask_wdata = 8'h00;
    Stall_F = 1'b0; PCSrc_E = 1'b0; PC_Target_E = 32'h0; PC_plus4_F = 32'h0; mret_E = 1'b0;

    // 1 Reset
    tick(); tick();
    check("rst_interrupt", 32'(interrupt), 32'h0);
    check("rst_mask", 32'(irq_mask), 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_in_service", 32'(in_service), 32'h0);
    check("rst_irq_id", 32'(irq_id), 32'h0);
    irq_src = 8'h00;
    rst = 1'b1;
    tick();
    check("rst_idle_interrupt", 32'(interrupt), 32'h0);

    // 2 Basic take
    mask_we = 1'b1; mask_wdata = 8'h04;
    tick();
    mask_we = 1'b0;
    check("t2_mask", 32'(irq_mask), 32'h04);
    irq_src = 8'h04; PC_plus4_F = 32'h48;
    wait_irq(ok);
    check("t2_fire", 32'(ok), 32'h1);
    check("t2_id_fire", 32'(irq_id), 32'h2);
    irq_src = 8'h00;
    tick();
    check("t2_int_low", 32'(interrupt), 32'h0);
    check("t2_in_service", 32'(in_service), 32'h1);
    check("t2_epc", epc, 32'h48);
    check("t2_id", 32'(irq_id), 32'h2);
    do_mret();
    check("t2_mret_in_service", 32'(in_service), 32'h0);
    check("t2_mret_int", 32'(interrupt), 32'h0);
    tick();
    check("t2_no_retake", 32'(interrupt), 32'h0);

    // 3 Priority
    mask_we = 1'b1; mask_wdata = 8'hFF;
    tick();
    mask_we = 1'b0;
    irq_src = 8'h22; PC_plus4_F = 32'h50;
    wait_irq(ok);
    check("t3_fire", 32'(ok), 32'h1);
    check("t3_id_first", 32'(irq_id), 32'h1);
    irq_src = 8'h20;
    tick();
    check("t3_in_service", 32'(in_service), 32'h1);
    check("t3_epc1", epc, 32'h50);
    do_mret();
    check("t3_gap", 32'(interrupt), 32'h0);
    PC_plus4_F = 32'h54;
    tick();
    check("t3_refire", 32'(interrupt), 32'h1);
    check("t3_id_second", 32'(irq_id), 32'h5);
    irq_src = 8'h00;
    tick();
    check("t3_epc2", epc, 32'h54);
    do_mret();

    // 4 Stall during FIRE (mret in FIRE must be ignored)
    irq_src = 8'h01; Stall_F = 1'b1; PC_plus4_F = 32'h60;
    wait_irq(ok);
    check("t4_fire", 32'(ok), 32'h1);
    check("t4_id", 32'(irq_id), 32'h0);
    irq_src = 8'h00; mret_E = 1'b1;
    tick();
    mret_E = 1'b0;
    check("t4_c2_int", 32'(interrupt), 32'h1);
    check("t4_c2_epc", epc, 32'h54);
    check("t4_c2_id", 32'(irq_id), 32'h0);
    tick();
    check("t4_c3_int", 32'(interrupt), 32'h1);
    check("t4_c3_epc", epc, 32'h54);
    tick();
    check("t4_c4_int", 32'(interrupt), 32'h1);
    Stall_F = 1'b0; PC_plus4_F = 32'h64;
    tick();
    check("t4_int_low", 32'(interrupt), 32'h0);
    check("t4_in_service", 32'(in_service), 32'h1);
    check("t4_epc", epc, 32'h64);
    do_mret();

    // 5 Branch collision on the take cycle
    irq_src = 8'h80; PCSrc_E = 1'b1; PC_Target_E = 32'h200; PC_plus4_F = 32'h70;
    wait_irq(ok);
    check("t5_fire", 32'(ok), 32'h1);
    check("t5_id", 32'(irq_id), 32'h7);
    irq_src = 8'h00;
    tick();
    PCSrc_E = 1'b0;
    check("t5_epc", epc, 32'h200);
    do_mret();

    // 6 Mask gating, re-request during SERVICE, mask write on take cycle
    mask_we = 1'b1; mask_wdata = 8'h00;
    tick();
    mask_we = 1'b0;
    irq_src = 8'h08;
    tick(); tick(); tick();
    check("t6_masked", 32'(interrupt), 32'h0);
    mask_we = 1'b1; mask_wdata = 8'h08;
    tick();
    mask_we = 1'b0;
    check("t6_mask", 32'(irq_mask), 32'h08);
    check("t6_not_yet", 32'(interrupt), 32'h0);
    tick();
    check("t6_fire", 32'(interrupt), 32'h1);
    check("t6_id", 32'(irq_id), 32'h3);
    irq_src = 8'h00; PC_plus4_F = 32'h80;
    tick();
    check("t6_in_service", 32'(in_service), 32'h1);
    check("t6_epc", epc, 32'h80);
    irq_src = 8'h08;
    tick();
`ifdef IRQ_EDGE_EN
    irq_src = 8'h00;
`endif
    tick();
    check("t6_svc_hold", 32'(in_service), 32'h1);
    check("t6_svc_no_int", 32'(interrupt), 32'h0);
    do_mret();
    check("t6_gap", 32'(interrupt), 32'h0);
    tick();
    check("t6_retake", 32'(interrupt), 32'h1);
    check("t6_retake_id", 32'(irq_id), 32'h3);
    irq_src = 8'h00; mask_we = 1'b1; mask_wdata = 8'h00;
    tick();
    mask_we = 1'b0;
    check("t6_take_with_mask_in_service", 32'(in_service), 32'h1);
    check("t6_take_with_mask_mask", 32'(irq_mask), 32'h00);

    // Reset mid-service
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_in_service", 32'(in_service), 32'h0);
    check("mid_rst_epc", epc, 32'h0);
    check("mid_rst_id", 32'(irq_id), 32'h0);
    tick();
    check("mid_rst_interrupt", 32'(interrupt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
